// File: rtl/rv32v_divider_if.sv
// Operand/result bundle between a vector-lane issuer and rv32v_divider.
// Latency: none (signal bundle only).
// Backpressure: none; start is only taken in IDLE/DONE, so the issuer watches busy/finished.
// Ports: dividend/divisor/is_signed/start (issuer -> divider),
//        busy/finished/quotient/remainder (divider -> issuer).
interface rv32v_divider_if #(
   parameter int BIT_WIDTH = 32
);
   logic [BIT_WIDTH-1:0] dividend;
   logic [BIT_WIDTH-1:0] divisor;
   logic                 is_signed;
   logic                 start;
   logic                 busy;
   logic                 finished;
   logic [BIT_WIDTH-1:0] quotient;
   logic [BIT_WIDTH-1:0] remainder;

   modport master (
      output dividend, divisor, is_signed, start,
      input  busy, finished, quotient, remainder
   );

   modport slave (
      input  dividend, divisor, is_signed, start,
      output busy, finished, quotient, remainder
   );
endinterface

// File: rtl/rv32v_divider.sv
// Iterative radix-2 restoring divider with RISC-V divide-by-zero / overflow results.
// Latency: BIT_WIDTH+2 cycles from accept to finished; 1 cycle for divide-by-zero or signed overflow.
// Backpressure: start is ignored while busy; start held high in DONE chains the next op with no bubble.
// Ports: CLK, nRST (async active-low), bus (slave side of rv32v_divider_if).
module rv32v_divider #(
   parameter int BIT_WIDTH = 32
) (
   input  logic            CLK,
   input  logic            nRST,
   rv32v_divider_if.slave  bus
);
   localparam int CW = $clog2(BIT_WIDTH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_FIXUP, S_DONE} state_t;

   state_t                r_state;
   state_t                w_next;
   logic [CW-1:0]         r_count;
   // The partial remainder always ends an iteration below the divisor, so
   // only the shifted working value needs the extra (BIT_WIDTH+1)th bit.
   logic [BIT_WIDTH-1:0]  r_rem;
   logic [BIT_WIDTH-1:0]  r_quo;
   logic [BIT_WIDTH-1:0]  r_div_mag;
   logic [BIT_WIDTH-1:0]  r_quotient;
   logic [BIT_WIDTH-1:0]  r_remainder;
   logic                  r_neg_quo;
   logic                  r_neg_rem;

   logic                  w_accept;
   logic                  w_div_zero;
   logic                  w_overflow;
   logic                  w_dvd_neg;
   logic                  w_dvs_neg;
   logic [BIT_WIDTH-1:0]  w_most_neg;
   logic [BIT_WIDTH-1:0]  w_dvd_mag;
   logic [BIT_WIDTH-1:0]  w_dvs_mag;
   logic [BIT_WIDTH:0]    w_rem_sh;
   logic [BIT_WIDTH:0]    w_trial;
   logic                  w_last;
   logic                  w_busy;
   logic                  w_finished;

   assign w_accept   = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_most_neg = {1'b1, {(BIT_WIDTH-1){1'b0}}};
   assign w_div_zero = (bus.divisor == '0);
   assign w_overflow = bus.is_signed && (bus.dividend == w_most_neg) && (bus.divisor == '1);
   assign w_dvd_neg  = bus.is_signed && bus.dividend[BIT_WIDTH-1];
   assign w_dvs_neg  = bus.is_signed && bus.divisor[BIT_WIDTH-1];
   // The most-negative value maps onto itself, which is its correct unsigned magnitude.
   assign w_dvd_mag  = w_dvd_neg ? -bus.dividend : bus.dividend;
   assign w_dvs_mag  = w_dvs_neg ? -bus.divisor  : bus.divisor;

   // One restoring step: shift the next dividend bit in, then try to subtract.
   assign w_rem_sh   = {r_rem, r_quo[BIT_WIDTH-1]};
   assign w_trial    = w_rem_sh - {1'b0, r_div_mag};
   assign w_last     = (r_count == CW'(BIT_WIDTH - 1));

   assign bus.busy      = w_busy;
   assign bus.finished  = w_finished;
   assign bus.quotient  = r_quotient;
   assign bus.remainder = r_remainder;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_busy     = 1'b0;
      w_finished = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_next = (w_div_zero || w_overflow) ? S_DONE : S_DIVIDE;
         end
         S_DIVIDE: begin
            w_busy = 1'b1;
            if (w_last) w_next = S_FIXUP;
         end
         S_FIXUP: begin
            w_busy = 1'b1;
            w_next = S_DONE;
         end
         S_DONE: begin
            w_finished = 1'b1;
            if (w_accept) w_next = (w_div_zero || w_overflow) ? S_DONE : S_DIVIDE;
            else          w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_count     <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_div_mag   <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_neg_quo   <= 1'b0;
         r_neg_rem   <= 1'b0;
      end else if (w_accept) begin
         r_count   <= '0;
         r_rem     <= '0;
         r_quo     <= w_dvd_mag;
         r_div_mag <= w_dvs_mag;
         r_neg_quo <= w_dvd_neg ^ w_dvs_neg;
         r_neg_rem <= w_dvd_neg;
         // Special cases publish their result immediately; divide-by-zero wins.
         if (w_div_zero) begin
            r_quotient  <= '1;
            r_remainder <= bus.dividend;
         end else if (w_overflow) begin
            r_quotient  <= bus.dividend;
            r_remainder <= '0;
         end
      end else if (r_state == S_DIVIDE) begin
         r_count <= r_count + 1'b1;
         if (!w_trial[BIT_WIDTH]) begin
            r_rem <= w_trial[BIT_WIDTH-1:0];
            r_quo <= {r_quo[BIT_WIDTH-2:0], 1'b1};
         end else begin
            r_rem <= w_rem_sh[BIT_WIDTH-1:0];
            r_quo <= {r_quo[BIT_WIDTH-2:0], 1'b0};
         end
      end else if (r_state == S_FIXUP) begin
         r_quotient  <= r_neg_quo ? -r_quo : r_quo;
         r_remainder <= r_neg_rem ? -r_rem : r_rem;
      end
   end
endmodule
